mem_copy_engine: RTL

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_pkg.sv | 15 +
 rtl/mem_range_check.sv | 38 +++
 rtl/mem_copy_engine.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the word-granular memory copy engine:
// FSM encodings, word step and address width.
package mem_copy_pkg;

  localparam int ADDR_W    = 32;
  localparam int WORD_STEP = 4;
  localparam int SUM_W     = ADDR_W + 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

endpackage

// File: rtl/mem_range_check.sv
// Combinational request validation: word alignment, memory bounds and copy direction.
// Latency: none. Backpressure: none, pure function of its inputs.
module mem_range_check
  import mem_copy_pkg::*;
#(
  parameter int MEMORY_SIZE = 64,
  parameter int LEN_W       = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              ok,
  output logic              descending
);

  logic [SUM_W-1:0] span;
  logic [SUM_W-1:0] src_ext;
  logic [SUM_W-1:0] dst_ext;
  logic [SUM_W-1:0] src_end;
  logic [SUM_W-1:0] dst_end;
  logic [SUM_W-1:0] mem_lim;
  logic             aligned;

  // Sums are two bits wider than an address so an oversized request cannot wrap into range.
  always_comb begin
    span    = SUM_W'(len) * SUM_W'(WORD_STEP);
    src_ext = SUM_W'(src);
    dst_ext = SUM_W'(dst);
    src_end = src_ext + span;
    dst_end = dst_ext + span;
    mem_lim = SUM_W'(MEMORY_SIZE);
    aligned = (src[1:0] == 2'b00) && (dst[1:0] == 2'b00);
    ok      = aligned && (src_end <= mem_lim) && (dst_end <= mem_lim);
    // Destination starting inside the source window would clobber unread words going upward.
    descending = (dst_ext > src_ext) && (dst_ext < src_end);
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Copies len 32-bit words from src to dst, one word per READ/WRITE pair (2 cycles/word, done at 2*len+1).
// Latency: done pulses 2*len+1 cycles after start is sampled. Backpressure: start is ignored while busy.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int MEMORY_SIZE = 64,
  parameter int LEN_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [ADDR_W-1:0] mem_rdata
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              desc_q, desc_d;
  logic              wr_en;
  logic              req_ok;
  logic              req_desc;
  logic [ADDR_W-1:0] last_off;
  logic [ADDR_W-1:0] step;

  mem_range_check #(
    .MEMORY_SIZE(MEMORY_SIZE),
    .LEN_W      (LEN_W)
  ) u_range (
    .src       (src),
    .dst       (dst),
    .len       (len),
    .ok        (req_ok),
    .descending(req_desc)
  );

  // Byte offset of the last word; only consumed for descending copies, where len is nonzero.
  assign last_off = (ADDR_W'(len) - ADDR_W'(1)) * ADDR_W'(WORD_STEP);
  assign step     = ADDR_W'(WORD_STEP);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    desc_d    = desc_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    wr_en     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = len;
          desc_d = req_desc;
          src_d  = req_desc ? src + last_off : src;
          dst_d  = req_desc ? dst + last_off : dst;
          if (!req_ok) begin
            state_d = ST_ERR;
          end else if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        busy     = 1'b1;
        mem_addr = src_q;
        data_d   = mem_rdata;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = data_q;
        wr_en     = 1'b1;
        cnt_d     = cnt_q - LEN_W'(1);
        src_d     = desc_q ? src_q - step : src_q + step;
        dst_d     = desc_q ? dst_q - step : dst_q + step;
        state_d   = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset kills a write in the very cycle it is asserted, not one edge later.
  assign mem_write = wr_en & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
    end
  end

endmodule
